// File: rtl/detect_seq_ctrl_pkg.sv
// Shared definitions for the 10010 detector-pair sequencer: state encoding and
// default widths.
package detect_pkg;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/detect_seq_ctrl_if.sv
// Control/result bus between the test-control register block (master) and the
// sequencer (slave).
interface detect_seq_ctrl_if #(
  parameter int WORD_W = detect_pkg::WORD_W,
  parameter int LEN_W  = detect_pkg::LEN_W,
  parameter int CNT_W  = detect_pkg::CNT_W
);

  logic              start;
  logic [WORD_W-1:0] word_in;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  mis_cnt;
  logic              mismatch;

  modport master (
    output start, word_in, len,
    input  busy, done, hit_cnt, mis_cnt, mismatch
  );

  modport slave (
    input  start, word_in, len,
    output busy, done, hit_cnt, mis_cnt, mismatch
  );

endinterface

// File: rtl/detect_seq_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/detect_seq_ctrl.sv
// Feeds one serial stream into a Moore/Mealy 10010 detector pair, aligns the
// Mealy output to the Moore output and counts hits and disagreements.
module detect_seq_ctrl #(
  parameter int WORD_W = detect_pkg::WORD_W,
  parameter int LEN_W  = detect_pkg::LEN_W,
  parameter int CNT_W  = detect_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  detect_seq_ctrl_if.slave      bus,
  input  logic                  det_moore,
  input  logic                  det_mealy,
  output logic                  j,
  output logic                  det_clr
);

  import detect_pkg::state_t;
  import detect_pkg::IDLE;
  import detect_pkg::CLEAR;
  import detect_pkg::SHIFT;
  import detect_pkg::DRAIN;
  import detect_pkg::DONE;

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  len_c;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              mealy_q;
  logic              cmp_en;
  logic              mismatch_q;
  logic              hit_inc;
  logic              mis_inc;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  mis_cnt;

  assign len_c  = (bus.len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : bus.len;
  assign accept = (state == IDLE) && bus.start;

  // The word is left-justified at latch time so the next bit is always the MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      word_q  <= '0;
      rem     <= '0;
      j       <= 1'b0;
      det_clr <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_q  <= bus.word_in << (LEN_W'(WORD_W) - len_c);
            rem     <= len_c;
            j       <= 1'b0;
            det_clr <= 1'b1;
            busy_q  <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          det_clr <= 1'b0;
          if (rem == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            j      <= word_q[WORD_W-1];
            word_q <= word_q << 1;
            rem    <= rem - LEN_W'(1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem == '0) begin
            j     <= 1'b0;
            state <= DRAIN;
          end else begin
            j      <= word_q[WORD_W-1];
            word_q <= word_q << 1;
            rem    <= rem - LEN_W'(1);
          end
        end
        DRAIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore lags Mealy by one cycle; delaying Mealy lines the two up for comparison.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mealy_q    <= 1'b0;
      cmp_en     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      mealy_q <= (state == SHIFT) && det_mealy;
      cmp_en  <= (state == SHIFT);
      if (accept) begin
        mismatch_q <= 1'b0;
      end else if (mis_inc) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign hit_inc = cmp_en && det_moore;
  assign mis_inc = cmp_en && (det_moore != mealy_q);

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (hit_inc),
    .cnt (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (mis_inc),
    .cnt (mis_cnt)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hit_cnt  = hit_cnt;
  assign bus.mis_cnt  = mis_cnt;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_detect_seq_ctrl.sv
// Directed bench for detect_seq_ctrl with overlapping 10010 Moore/Mealy
// reference detectors; a second instance with CNT_W=2 covers saturation.
module tb_detect_seq_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  detect_seq_ctrl_if #(.WORD_W(16), .LEN_W(5), .CNT_W(8)) a_bus ();
  detect_seq_ctrl_if #(.WORD_W(16), .LEN_W(5), .CNT_W(2)) b_bus ();

  logic a_j, a_det_clr, a_moore, a_mealy;
  logic b_j, b_det_clr, b_moore, b_mealy;
  logic kill_mealy;

  detect_seq_ctrl #(.WORD_W(16), .LEN_W(5), .CNT_W(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (a_bus),
    .det_moore (a_moore),
    .det_mealy (a_mealy),
    .j         (a_j),
    .det_clr   (a_det_clr)
  );

  detect_seq_ctrl #(.WORD_W(16), .LEN_W(5), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (b_bus),
    .det_moore (b_moore),
    .det_mealy (b_mealy),
    .j         (b_j),
    .det_clr   (b_det_clr)
  );

  // Reference detectors; state value = length of matched 10010 prefix.
  function automatic logic [2:0] moore_nx(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd1 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      3'd4:    return b ? 3'd1 : 3'd5;
      3'd5:    return b ? 3'd1 : 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] mealy_nx(input logic [2:0] s, input logic b);
    case (s)
      3'd4:    return b ? 3'd1 : 3'd2;
      default: return moore_nx(s, b);
    endcase
  endfunction

  logic [2:0] a_moore_st, a_mealy_st, b_moore_st, b_mealy_st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_moore_st <= 3'd0;
      a_mealy_st <= 3'd0;
      b_moore_st <= 3'd0;
      b_mealy_st <= 3'd0;
    end else begin
      a_moore_st <= a_det_clr ? 3'd0 : moore_nx(a_moore_st, a_j);
      a_mealy_st <= a_det_clr ? 3'd0 : mealy_nx(a_mealy_st, a_j);
      b_moore_st <= b_det_clr ? 3'd0 : moore_nx(b_moore_st, b_j);
      b_mealy_st <= b_det_clr ? 3'd0 : mealy_nx(b_mealy_st, b_j);
    end
  end

  assign a_moore = (a_moore_st == 3'd5);
  assign a_mealy = (a_mealy_st == 3'd4) && !a_j && !kill_mealy;
  assign b_moore = (b_moore_st == 3'd5);
  assign b_mealy = (b_mealy_st == 3'd4) && !b_j;

  // One run on instance A: start pulse, optional extra start at cycle poke,
  // capture of the SHIFT-phase stream, det_clr cycles and done position.
  task automatic run_a(input logic [15:0] w, input logic [4:0] l, input int poke,
                       output logic [15:0] stream, output int done_cyc,
                       output int clr_cyc);
    @(negedge clk);
    a_bus.word_in = w;
    a_bus.len     = l;
    a_bus.start   = 1'b1;
    stream   = '0;
    done_cyc = -1;
    clr_cyc  = 0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      a_bus.start = (c == poke);
      if (a_det_clr) clr_cyc++;
      if (c >= 2 && c <= int'(l) + 1) stream = {stream[14:0], a_j};
      if (a_bus.done) done_cyc = c;
    end
    a_bus.start = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    logic [7:0] got;
    got = {a_j, a_det_clr, a_bus.busy, a_bus.done, a_bus.mismatch,
           b_j, b_bus.busy, b_bus.done};
    n_tests++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_flags: got %b want 00000000", tag, got);
    end
    n_tests++;
    if (a_bus.hit_cnt !== 8'd0 || a_bus.mis_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL %s_counts: got hit=%0d mis=%0d want 0 0", tag,
               a_bus.hit_cnt, a_bus.mis_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    kill_mealy = 1'b0;
    a_bus.start = 1'b0; a_bus.word_in = '0; a_bus.len = '0;
    b_bus.start = 1'b0; b_bus.word_in = '0; b_bus.len = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("idle");
  endtask

  task automatic check_t1(input string tag, input logic [15:0] stream,
                          input int done_cyc);
    n_tests++;
    if (stream[8:0] !== 9'h125) begin
      n_fail++;
      $display("FAIL %s_stream: got %b want 100100101", tag, stream[8:0]);
    end
    n_tests++;
    if (a_bus.hit_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL %s_hit: got %0d want 2", tag, a_bus.hit_cnt);
    end
    n_tests++;
    if (a_bus.mis_cnt !== 8'd0 || a_bus.mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_mis: got %0d/%b want 0/0", tag, a_bus.mis_cnt, a_bus.mismatch);
    end
    n_tests++;
    if (done_cyc != 12) begin
      n_fail++;
      $display("FAIL %s_done: got cycle %0d want 12", tag, done_cyc);
    end
  endtask

  task automatic test_stream;
    logic [15:0] s;
    int d, k;
    run_a(16'h0125, 5'd9, 0, s, d, k);
    check_t1("t1", s, d);
    n_tests++;
    if (k != 1) begin
      n_fail++;
      $display("FAIL t1_clr: got %0d cycles want 1", k);
    end
    // Results must hold after done.
    repeat (3) @(negedge clk);
    n_tests++;
    if (a_bus.hit_cnt !== 8'd2 || a_bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_hold: got hit=%0d busy=%b want 2 0", a_bus.hit_cnt, a_bus.busy);
    end
  endtask

  task automatic test_len_zero;
    logic [15:0] s;
    int d, k;
    run_a(16'hFFFF, 5'd0, 0, s, d, k);
    n_tests++;
    if (k != 1) begin
      n_fail++;
      $display("FAIL t2_clr: got %0d cycles want 1", k);
    end
    n_tests++;
    if (d != 2) begin
      n_fail++;
      $display("FAIL t2_done: got cycle %0d want 2", d);
    end
    n_tests++;
    if (a_bus.hit_cnt !== 8'd0 || a_bus.mis_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL t2_counts: got hit=%0d mis=%0d want 0 0", a_bus.hit_cnt, a_bus.mis_cnt);
    end
  endtask

  task automatic test_mealy_stuck;
    logic [15:0] s;
    int d, k;
    kill_mealy = 1'b1;
    run_a(16'h0125, 5'd9, 0, s, d, k);
    kill_mealy = 1'b0;
    n_tests++;
    if (a_bus.mis_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL t3_mis: got %0d want 2", a_bus.mis_cnt);
    end
    n_tests++;
    if (a_bus.mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_flag: got %b want 1", a_bus.mismatch);
    end
    n_tests++;
    if (a_bus.hit_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL t3_hit: got %0d want 2", a_bus.hit_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    int d, k;
    run_a(16'h0125, 5'd9, 5, s, d, k);
    check_t1("t4", s, d);
    n_tests++;
    if (k != 1) begin
      n_fail++;
      $display("FAIL t4_clr: got %0d cycles want 1", k);
    end
  endtask

  task automatic test_abort;
    logic [15:0] s;
    int d, k, seen;
    @(negedge clk);
    a_bus.word_in = 16'h0125;
    a_bus.len     = 5'd9;
    a_bus.start   = 1'b1;
    @(negedge clk);
    a_bus.start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (a_bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_busy: got %b want 1", a_bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    check_zero_outputs("t5_async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_bus.done) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL t5_nodone: got %0d pulses want 0", seen);
    end
    run_a(16'h0125, 5'd9, 0, s, d, k);
    check_t1("t5_rerun", s, d);
  endtask

  task automatic test_saturate;
    int done_cyc;
    @(negedge clk);
    b_bus.word_in = 16'h4924;
    b_bus.len     = 5'd16;
    b_bus.start   = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      b_bus.start = 1'b0;
      if (b_bus.done) done_cyc = c;
    end
    n_tests++;
    if (done_cyc != 19) begin
      n_fail++;
      $display("FAIL t6_done: got cycle %0d want 19", done_cyc);
    end
    n_tests++;
    if (b_bus.hit_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL t6_hit: got %0d want 3", b_bus.hit_cnt);
    end
    n_tests++;
    if (b_bus.mis_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL t6_mis: got %0d want 0", b_bus.mis_cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_stream();
    test_len_zero();
    test_mealy_stuck();
    test_back_to_back();
    test_abort();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
